// File: rtl/uart_pkg.sv
// uart_pkg: mode encoding and level-width helper shared by the UART stream bridge.
package uart_pkg;

    typedef enum logic [1:0] {
        HOST  = 2'd0,
        LOOP  = 2'd1,
        DRAIN = 2'd2
    } mode_state_e;

    function automatic int level_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with flop storage, occupancy level and synchronous flush.
module sync_fifo
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic                          push,
    input  logic [DATA_WIDTH-1:0]         push_data,
    input  logic                          pop,
    output logic [DATA_WIDTH-1:0]         pop_data,
    output logic [level_width(DEPTH)-1:0] level,
    output logic                          full,
    output logic                          empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = level_width(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr, rd_ptr;
    logic                  do_push, do_pop;

    // Full is judged on the registered level only, so a same-cycle pop never frees a slot.
    assign full     = level == LW'(DEPTH);
    assign empty    = level == '0;
    assign do_push  = push && !full && !flush;
    assign do_pop   = pop && !empty && !flush;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            level <= level + LW'(do_push) - LW'(do_pop);
        end
    end

endmodule

// File: rtl/uart_stream_bridge.sv
// uart_stream_bridge: RX/TX buffering between uart_rx/uart_tx and a host stream,
// with loopback echo, drop accounting and drain-before-switch mode control.
module uart_stream_bridge
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int RX_DEPTH   = 16,
    parameter int TX_DEPTH   = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             loopback,
    input  logic                             flush,
    input  logic [DATA_WIDTH-1:0]            uart_rx_tdata,
    input  logic                             uart_rx_tvalid,
    output logic                             uart_rx_tready,
    output logic [DATA_WIDTH-1:0]            uart_tx_tdata,
    output logic                             uart_tx_tvalid,
    input  logic                             uart_tx_tready,
    output logic [DATA_WIDTH-1:0]            host_rx_tdata,
    output logic                             host_rx_tvalid,
    input  logic                             host_rx_tready,
    input  logic [DATA_WIDTH-1:0]            host_tx_tdata,
    input  logic                             host_tx_tvalid,
    output logic                             host_tx_tready,
    output logic [level_width(RX_DEPTH)-1:0] rx_level,
    output logic [level_width(TX_DEPTH)-1:0] tx_level,
    output logic [CNT_WIDTH-1:0]             drop_count,
    output logic                             overflow,
    output logic [1:0]                       mode_state
);
    mode_state_e           state, state_n;
    logic                  rdy;
    logic                  rx_push, rx_pop, rx_full, rx_empty;
    logic                  tx_push, tx_pop, tx_full, tx_empty;
    logic                  drop_evt;
    logic [DATA_WIDTH-1:0] rx_data, tx_push_data;

    assign uart_rx_tready = rdy;
    assign rx_push        = uart_rx_tvalid && rdy;
    assign drop_evt       = rx_push && rx_full && !flush;
    assign uart_tx_tvalid = !tx_empty;
    assign tx_pop         = uart_tx_tvalid && uart_tx_tready;
    assign host_rx_tdata  = rx_data;
    assign mode_state     = state;

    always_comb begin
        state_n        = state;
        rx_pop         = 1'b0;
        tx_push        = 1'b0;
        tx_push_data   = host_tx_tdata;
        host_rx_tvalid = 1'b0;
        host_tx_tready = 1'b0;
        case (state)
            HOST: begin
                host_rx_tvalid = !rx_empty;
                host_tx_tready = rdy && !tx_full;
                rx_pop         = host_rx_tvalid && host_rx_tready;
                tx_push        = host_tx_tvalid && host_tx_tready;
                state_n        = loopback ? DRAIN : HOST;
            end
            LOOP: begin
                rx_pop       = !rx_empty && !tx_full;
                tx_push      = rx_pop;
                tx_push_data = rx_data;
                state_n      = loopback ? LOOP : DRAIN;
            end
            DRAIN: begin
                // A flush empties TX at this edge, so the drain is over as well.
                if (tx_empty || flush) state_n = loopback ? LOOP : HOST;
            end
            default: state_n = HOST;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= HOST;
            rdy        <= 1'b0;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else begin
            state    <= state_n;
            rdy      <= 1'b1;
            overflow <= drop_evt;
            if (drop_evt && !(&drop_count)) drop_count <= drop_count + 1'b1;
        end
    end

    sync_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .push      (rx_push),
        .push_data (uart_rx_tdata),
        .pop       (rx_pop),
        .pop_data  (rx_data),
        .level     (rx_level),
        .full      (rx_full),
        .empty     (rx_empty)
    );

    sync_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .push      (tx_push),
        .push_data (tx_push_data),
        .pop       (tx_pop),
        .pop_data  (uart_tx_tdata),
        .level     (tx_level),
        .full      (tx_full),
        .empty     (tx_empty)
    );

endmodule

// File: tb/tb_uart_stream_bridge.sv
// tb_uart_stream_bridge: queue-based reference model checked every cycle, plus directed
// scenarios with literal expectations for host TX/RX, overflow, loopback, drain, flush and reset.
module tb_uart_stream_bridge;
    localparam int RXD  = 4;
    localparam int TXD  = 16;
    localparam int CW   = 3;
    localparam int DMAX = 7;

    logic       clk = 1'b0, rst = 1'b1, loopback = 1'b0, flush = 1'b0;
    logic [7:0] uart_rx_tdata = '0, uart_tx_tdata, host_rx_tdata, host_tx_tdata = '0;
    logic       uart_rx_tvalid = 1'b0, uart_rx_tready, uart_tx_tvalid, uart_tx_tready = 1'b0;
    logic       host_rx_tvalid, host_rx_tready = 1'b0, host_tx_tvalid = 1'b0, host_tx_tready;
    logic [2:0] rx_level;
    logic [4:0] tx_level;
    logic [CW-1:0] drop_count;
    logic       overflow;
    logic [1:0] mode_state;

    uart_stream_bridge #(.DATA_WIDTH(8), .RX_DEPTH(RXD), .TX_DEPTH(TXD), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .loopback(loopback), .flush(flush),
        .uart_rx_tdata(uart_rx_tdata), .uart_rx_tvalid(uart_rx_tvalid), .uart_rx_tready(uart_rx_tready),
        .uart_tx_tdata(uart_tx_tdata), .uart_tx_tvalid(uart_tx_tvalid), .uart_tx_tready(uart_tx_tready),
        .host_rx_tdata(host_rx_tdata), .host_rx_tvalid(host_rx_tvalid), .host_rx_tready(host_rx_tready),
        .host_tx_tdata(host_tx_tdata), .host_tx_tvalid(host_tx_tvalid), .host_tx_tready(host_tx_tready),
        .rx_level(rx_level), .tx_level(tx_level), .drop_count(drop_count),
        .overflow(overflow), .mode_state(mode_state)
    );

    always #5 clk = ~clk;

    int n_tests = 0, n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_seq(input string nm, input logic [7:0] q[$], input int n, input logic [31:0] e);
        chk({nm, "_count"}, q.size(), n);
        for (int i = 0; i < n; i++)
            chk(nm, (i < q.size()) ? {24'h0, q[i]} : 32'hxx, {24'h0, e[31-8*i -: 8]});
    endtask

    // Reference model: FIFOs as queues, mode as 0=HOST,1=LOOP,2=DRAIN.
    logic [7:0] rxq[$], txq[$];
    bit  started = 0, m_rdy = 0, m_ovf = 0;
    int  m_state = 0, m_drop = 0;

    always @(posedge clk) begin
        int nrx, ntx, ns;
        bit txp, rxp, rxpush, htx;
        logic [7:0] w;
        started = 1;
        if (rst) begin
            rxq.delete(); txq.delete();
            m_rdy = 0; m_state = 0; m_drop = 0; m_ovf = 0;
        end else begin
            nrx = rxq.size(); ntx = txq.size();
            txp = ntx > 0 && uart_tx_tready;
            rxp = (m_state == 0) ? (nrx > 0 && host_rx_tready) :
                  (m_state == 1) ? (nrx > 0 && ntx < TXD) : 1'b0;
            rxpush = uart_rx_tvalid && m_rdy;
            htx = m_state == 0 && m_rdy && host_tx_tvalid && ntx < TXD;
            m_ovf = rxpush && nrx == RXD && !flush;
            if (m_ovf && m_drop < DMAX) m_drop++;
            ns = (m_state == 0) ? (loopback ? 2 : 0) :
                 (m_state == 1) ? (loopback ? 1 : 2) :
                 ((ntx == 0 || flush) ? (loopback ? 1 : 0) : 2);
            if (flush) begin
                rxq.delete(); txq.delete();
            end else begin
                w = 8'h00;
                if (txp) void'(txq.pop_front());
                if (rxp) w = rxq.pop_front();
                if (rxpush && nrx < RXD) rxq.push_back(uart_rx_tdata);
                if (htx) txq.push_back(host_tx_tdata);
                if (m_state == 1 && rxp) txq.push_back(w);
            end
            m_state = ns;
            m_rdy = 1;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("uart_rx_tready", uart_rx_tready, m_rdy);
            chk("host_tx_tready", host_tx_tready, m_rdy && m_state == 0 && txq.size() < TXD);
            chk("uart_tx_tvalid", uart_tx_tvalid, txq.size() > 0);
            chk("host_rx_tvalid", host_rx_tvalid, m_state == 0 && rxq.size() > 0);
            chk("rx_level", rx_level, rxq.size());
            chk("tx_level", tx_level, txq.size());
            chk("drop_count", drop_count, m_drop);
            chk("overflow", overflow, m_ovf);
            chk("mode_state", mode_state, m_state);
            if (txq.size() > 0) chk("uart_tx_tdata", uart_tx_tdata, txq[0]);
            if (rxq.size() > 0 && m_state == 0) chk("host_rx_tdata", host_rx_tdata, rxq[0]);
        end
    end

    logic [7:0] utx_log[$], hrx_log[$];
    int  ovf_cnt = 0;
    bit  hrx_seen = 0;

    always @(negedge clk) begin
        if (!rst && uart_tx_tvalid && uart_tx_tready) utx_log.push_back(uart_tx_tdata);
        if (!rst && host_rx_tvalid && host_rx_tready) hrx_log.push_back(host_rx_tdata);
        if (overflow) ovf_cnt++;
        if (host_rx_tvalid) hrx_seen = 1;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rx_word(input logic [7:0] d);
        uart_rx_tvalid = 1'b1; uart_rx_tdata = d;
        cyc(1);
        uart_rx_tvalid = 1'b0;
    endtask

    task automatic htx_word(input logic [7:0] d);
        host_tx_tvalid = 1'b1; host_tx_tdata = d;
        cyc(1);
        host_tx_tvalid = 1'b0;
    endtask

    initial begin
        cyc(2);
        chk("rst_uart_rx_tready", uart_rx_tready, 0);
        chk("rst_host_tx_tready", host_tx_tready, 0);
        chk("rst_levels", {rx_level, tx_level}, 0);
        chk("rst_mode", mode_state, 0);
        rst = 1'b0;
        cyc(1);
        chk("post_rst_uart_rx_tready", uart_rx_tready, 1);

        // Host TX with the transmitter stalled, then released.
        htx_word(8'h55); htx_word(8'hA3); htx_word(8'hFF);
        chk("htx_level3", tx_level, 3);
        chk("htx_tready_held", host_tx_tready, 1);
        utx_log.delete();
        uart_tx_tready = 1'b1;
        cyc(4);
        chk("htx_level0", tx_level, 0);
        chk_seq("htx_out", utx_log, 3, 32'h55A3FF00);

        // Host RX, first valid one cycle after the first push.
        host_rx_tready = 1'b1;
        hrx_log.delete();
        chk("hrx_valid_before", host_rx_tvalid, 0);
        uart_rx_tvalid = 1'b1; uart_rx_tdata = 8'h11;
        cyc(1);
        chk("hrx_valid_latency", host_rx_tvalid, 1);
        uart_rx_tdata = 8'h22; cyc(1);
        uart_rx_tdata = 8'h33; cyc(1);
        uart_rx_tvalid = 1'b0;
        cyc(3);
        chk_seq("hrx_out", hrx_log, 3, 32'h11223300);

        // Overflow with RX full.
        host_rx_tready = 1'b0;
        ovf_cnt = 0;
        for (int i = 1; i <= 6; i++) rx_word(8'(i));
        cyc(1);
        chk("ovf_rx_level", rx_level, 4);
        chk("ovf_drop", drop_count, 2);
        chk("ovf_pulses", ovf_cnt, 2);
        hrx_log.delete();
        host_rx_tready = 1'b1;
        cyc(6);
        chk_seq("ovf_readout", hrx_log, 4, 32'h01020304);

        // Loopback entry with TX empty, then echo.
        loopback = 1'b1;
        cyc(1);
        chk("lb_drain", mode_state, 2);
        cyc(1);
        chk("lb_loop", mode_state, 1);
        utx_log.delete();
        hrx_seen = 0;
        rx_word(8'h55); rx_word(8'hA3);
        cyc(5);
        chk_seq("lb_echo", utx_log, 2, 32'h55A30000);
        chk("lb_no_host_rx", hrx_seen, 0);

        // Drain hold: TX must empty before entering LOOP.
        loopback = 1'b0;
        cyc(3);
        chk("dh_host", mode_state, 0);
        uart_tx_tready = 1'b0;
        htx_word(8'h10); htx_word(8'h20); htx_word(8'h30);
        loopback = 1'b1;
        cyc(1);
        chk("dh_drain", mode_state, 2);
        chk("dh_htx_tready", host_tx_tready, 0);
        rx_word(8'h77);
        cyc(2);
        chk("dh_still_drain", mode_state, 2);
        chk("dh_rx_kept", rx_level, 1);
        chk("dh_tx_held", tx_level, 3);
        utx_log.delete();
        uart_tx_tready = 1'b1;
        cyc(3);
        chk("dh_tx_empty", tx_level, 0);
        chk("dh_drain_last", mode_state, 2);
        cyc(1);
        chk("dh_loop", mode_state, 1);
        cyc(4);
        chk_seq("dh_out", utx_log, 4, 32'h10203077);

        // Flush with both FIFOs occupied and a same-cycle RX word.
        loopback = 1'b0;
        cyc(3);
        chk("fl_host", mode_state, 0);
        uart_tx_tready = 1'b0; host_rx_tready = 1'b0;
        uart_rx_tvalid = 1'b1; host_tx_tvalid = 1'b1;
        uart_rx_tdata = 8'hA1; host_tx_tdata = 8'hB1; cyc(1);
        uart_rx_tdata = 8'hA2; host_tx_tdata = 8'hB2; cyc(1);
        host_tx_tvalid = 1'b0;
        uart_rx_tdata = 8'hA3; cyc(1);
        uart_rx_tvalid = 1'b0;
        chk("fl_pre_rx", rx_level, 3);
        chk("fl_pre_tx", tx_level, 2);
        flush = 1'b1; uart_rx_tvalid = 1'b1; uart_rx_tdata = 8'hEE;
        cyc(1);
        flush = 1'b0; uart_rx_tvalid = 1'b0;
        chk("fl_rx0", rx_level, 0);
        chk("fl_tx0", tx_level, 0);
        chk("fl_drop_kept", drop_count, 2);

        // Flush while RX is full: the arriving word is not a drop.
        for (int i = 0; i < 4; i++) rx_word(8'hC0 + 8'(i));
        flush = 1'b1; uart_rx_tvalid = 1'b1;
        cyc(1);
        flush = 1'b0; uart_rx_tvalid = 1'b0;
        chk("flf_drop", drop_count, 2);
        chk("flf_ovf", overflow, 0);
        chk("flf_rx0", rx_level, 0);

        // Drop counter saturation at all-ones.
        for (int i = 0; i < 12; i++) rx_word(8'(i));
        cyc(1);
        chk("sat_drop", drop_count, DMAX);
        flush = 1'b1; cyc(1); flush = 1'b0;

        // Reset in the middle of host transfers.
        htx_word(8'h42);
        host_tx_tvalid = 1'b1; host_tx_tdata = 8'h99; uart_rx_tvalid = 1'b1; rst = 1'b1;
        cyc(1);
        chk("mr_uart_rx_tready", uart_rx_tready, 0);
        chk("mr_host_tx_tready", host_tx_tready, 0);
        chk("mr_valids", {uart_tx_tvalid, host_rx_tvalid}, 0);
        chk("mr_levels", {rx_level, tx_level}, 0);
        chk("mr_drop", drop_count, 0);
        chk("mr_ovf_mode", {overflow, mode_state}, 0);
        host_tx_tvalid = 1'b0; uart_rx_tvalid = 1'b0; rst = 1'b0;
        cyc(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
